// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: receiving end of the (x, y, colour, plot) pixel-plot interface.
// Plot writes land in a 160x120, 3-bit-per-pixel framebuffer.
// The framebuffer is scanned out continuously as 640x480 @ 60 Hz VGA, with each
// logical pixel shown as a 4x4 block.
//
// Optional feature: define VGA_PIXEL_SINK_CLEAR_EN to add a clear sequencer.
// After reset it zeroes the framebuffer, raising busy and ignoring plots while it runs.
//
// Ports:
//   clock        50 MHz system clock
//   resetn       asynchronous active-low reset (registers only, not RAM)
//   x, y         logical column 0..159 / row 0..119; out-of-range writes dropped
//   colour       {R,G,B} pixel value
//   plot         write strobe, sampled every clock
//   frame_start  one-clock pulse at the start of vertical blanking
//   busy         high while the clear sequencer runs (0 without the feature)
//   VGA_CLK      25 MHz pixel clock
//   VGA_HS/VS    active-low syncs
//   VGA_BLANK_N  low outside the visible region
//   VGA_SYNC_N   constant 1
//   VGA_R/G/B    10-bit colour channels
module vga_pixel_sink #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       frame_start,
  output logic       busy,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned FB_SIZE  = 160 * 120;

  logic        pix_en;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        hs_raw;
  logic        vs_raw;
  logic        vis;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic        hs_d1;
  logic        vs_d1;
  logic        vis_d1;

  logic [14:0] plot_addr;
  logic        plot_ok;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;

  logic [2:0]  mem [0:FB_SIZE-1];

  // Raw timing decoded straight from the counters.
  always_comb begin
    hs_raw  = !((h_cnt >= 10'(HS_START)) && (h_cnt <= 10'(HS_END)));
    vs_raw  = !((v_cnt >= 10'(VS_START)) && (v_cnt <= 10'(VS_END)));
    vis     = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    // row*160 as (row<<7)+(row<<5); only meaningful while vis=1.
    rd_addr = 15'({v_cnt[9:2], 7'b0}) + 15'({v_cnt[9:2], 5'b0}) + 15'(h_cnt[9:2]);
  end

  // Timing chain: counters -> stage 1 (RAM read + raw syncs) -> stage 2 (pins).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_en      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      vis_d1      <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == 10'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          if (v_cnt == 10'(V_TOTAL - 1)) begin
            v_cnt <= '0;
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
        hs_d1       <= hs_raw;
        vs_d1       <= vs_raw;
        vis_d1      <= vis;
        VGA_HS      <= hs_d1;
        VGA_VS      <= vs_d1;
        VGA_BLANK_N <= vis_d1;
        VGA_R       <= vis_d1 ? {10{rd_data[2]}} : '0;
        VGA_G       <= vis_d1 ? {10{rd_data[1]}} : '0;
        VGA_B       <= vis_d1 ? {10{rd_data[0]}} : '0;
      end
    end
  end

  // Synchronous RAM read, sampled on pixel ticks; the RAM has no reset.
  always_ff @(posedge clock) begin
    if (pix_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  always_comb begin
    plot_addr = 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
    plot_ok   = plot && (x < 8'd160) && (y < 7'd120);
  end

`ifdef VGA_PIXEL_SINK_CLEAR_EN
  typedef enum logic [1:0] {CLR_START, CLR_RUN, CLR_DONE} clr_state_t;

  clr_state_t  clr_state;
  clr_state_t  clr_next;
  logic [14:0] clr_addr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clr_state <= CLR_START;
      clr_addr  <= '0;
    end else begin
      clr_state <= clr_next;
      if (clr_state == CLR_RUN) begin
        clr_addr <= clr_addr + 15'd1;
      end
    end
  end

  always_comb begin
    clr_next = clr_state;
    case (clr_state)
      CLR_START: clr_next = CLR_RUN;
      CLR_RUN:   if (clr_addr == 15'(FB_SIZE - 1)) clr_next = CLR_DONE;
      CLR_DONE:  clr_next = CLR_DONE;
      default:   clr_next = CLR_DONE;
    endcase
  end

  always_comb begin
    busy = (clr_state == CLR_RUN);
  end

  // The sweep owns the write port while busy; plot writes are discarded.
  always_comb begin
    wr_en   = plot_ok;
    wr_addr = plot_addr;
    wr_data = colour;
    if (busy) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end
  end
`else
  always_comb begin
    busy    = 1'b0;
    wr_en   = plot_ok;
    wr_addr = plot_addr;
    wr_data = colour;
  end
`endif

  // Full-rate write port; a same-address read on this clock still sees old data.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    VGA_CLK     = pix_en;
    VGA_SYNC_N  = 1'b1;
    frame_start = pix_en && (h_cnt == '0) && (v_cnt == 10'(V_VISIBLE));
  end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// tb_vga_pixel_sink: randomized plot traffic against a reference model of the
// pixel sink. The model derives every output from the number of clocks since reset
// release, and from a plain array image of the framebuffer.
// The vertical geometry is shortened so that whole frames fit in a short run.
module tb_vga_pixel_sink;

  localparam int unsigned V_VIS   = 16;
  localparam int unsigned V_FP    = 2;
  localparam int unsigned V_SW    = 2;
  localparam int unsigned V_BP    = 2;
  localparam int unsigned H_TOT   = 800;
  localparam int unsigned V_TOT   = V_VIS + V_FP + V_SW + V_BP;
  localparam int unsigned FRAME   = H_TOT * V_TOT;
  localparam int unsigned FB_SIZE = 19200;
  localparam int unsigned CLR_LEN = 19200;
`ifdef VGA_PIXEL_SINK_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       frame_start, busy, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] VGA_R, VGA_G, VGA_B;

  vga_pixel_sink #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP)
  ) dut (
    .clock(clock), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .frame_start(frame_start), .busy(busy), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned tag;
    logic [36:0] val;
    logic [36:0] mask;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference framebuffer; known=0 marks contents nobody has written yet.
  logic [2:0]  ref_mem [FB_SIZE];
  bit          ref_known [FB_SIZE];
  int unsigned n = 0;             // clock edges since reset release
  logic [2:0]  cap_col = '0;      // pixel fetched on the latest pixel tick
  bit          cap_known = 1'b1;
  logic [2:0]  pin_col = '0;      // pixel being shown on the pins
  bit          pin_known = 1'b1;

  initial begin
    for (int i = 0; i < int'(FB_SIZE); i++) ref_known[i] = 1'b0;
  end

  // Account for the clock edge just gone, using the inputs held across it.
  task automatic model_edge();
    int unsigned nb, k, pos, h, v, a;
    bit busy_before;
    if (!resetn) begin
      n = 0;
      return;
    end
    nb = n;
    n  = n + 1;
    busy_before = CLEAR && (nb >= 1) && (nb <= CLR_LEN);
    // Pixel ticks fall on every second edge after release.
    if (n % 2 == 0) begin
      k   = n / 2;
      pos = (k - 1) % FRAME;
      h   = pos % H_TOT;
      v   = pos / H_TOT;
      pin_col   = cap_col;
      pin_known = cap_known;
      if (h < 640 && v < V_VIS) begin
        a         = (v / 4) * 160 + h / 4;
        cap_col   = ref_mem[a];
        cap_known = ref_known[a];
      end else begin
        cap_col   = '0;
        cap_known = 1'b0;
      end
    end
    if (plot && !busy_before && int'(x) < 160 && int'(y) < 120) begin
      a            = int'(y) * 160 + int'(x);
      ref_mem[a]   = colour;
      ref_known[a] = 1'b1;
    end
    if (busy_before) begin
      ref_mem[nb - 1]   = '0;
      ref_known[nb - 1] = 1'b1;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int unsigned k, p, h, v;
    bit hs, vs, bl, fs, bz, known;
    logic [2:0] c;
    k = n / 2;
    if (k < 2) begin
      hs = 1'b1; vs = 1'b1; bl = 1'b0; c = '0; known = 1'b1;
    end else begin
      p  = (k - 2) % FRAME;
      h  = p % H_TOT;
      v  = p / H_TOT;
      hs = !(h >= 656 && h <= 751);
      vs = !(v >= V_VIS + V_FP && v <= V_VIS + V_FP + V_SW - 1);
      bl = (h < 640) && (v < V_VIS);
      c     = bl ? pin_col : 3'b000;
      known = bl ? pin_known : 1'b1;
    end
    fs = (n % 2 == 1) && ((k % FRAME) == V_VIS * H_TOT);
    bz = CLEAR && (n >= 1) && (n <= CLR_LEN);
    e.tag  = n;
    e.val  = {(n % 2 == 1), hs, vs, bl, fs, bz, 1'b1,
              {10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    e.mask = {7'h7F, known ? 30'h3FFF_FFFF : 30'h0};
    sb.push_back(e);
  endtask

  // Monitor: every clock the DUT presents a new set of outputs.
  initial begin
    exp_t e;
    logic [36:0] act;
    forever begin
      @(negedge clock);
      #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, busy, VGA_SYNC_N,
               VGA_R, VGA_G, VGA_B};
        vectors++;
        if ((act & e.mask) !== (e.val & e.mask)) begin
          miscompares++;
          $display("FAIL vga_out edge=%0d actual=%h expected=%h mask=%h",
                   e.tag, act, e.val, e.mask);
        end
      end
    end
  end

  task automatic step_begin();
    @(negedge clock);
    model_edge();
    push_expected();
    #2;
  endtask

  task automatic idle_cycle();
    step_begin();
    plot = 1'b0;
  endtask

  task automatic rand_cycle();
    step_begin();
    plot   = ($urandom_range(7) == 0);
    x      = 8'($urandom_range(171));
    y      = ($urandom_range(7) == 0) ? 7'($urandom_range(127, 116)) : 7'($urandom_range(3));
    colour = 3'($urandom);
  endtask

  task automatic plot_cycle(input int unsigned px, input int unsigned py, input logic [2:0] pc);
    step_begin();
    plot   = 1'b1;
    x      = 8'(px);
    y      = 7'(py);
    colour = pc;
  endtask

  initial begin
    resetn = 1'b0;
    plot   = 1'b0;
    x      = '0;
    y      = '0;
    colour = '0;
    repeat (5) idle_cycle();
    resetn = 1'b1;
    // Run into the first frame (and into the clear sweep, at address 5000).
    repeat (5002) rand_cycle();
    plot   = 1'b0;
    resetn = 1'b0;
    repeat (5) idle_cycle();
    resetn = 1'b1;
    if (CLEAR) begin
      repeat (CLR_LEN + 100) rand_cycle();
    end
    plot_cycle(0, 2, 3'b101);
    plot_cycle(0, 0, 3'b100);
    plot_cycle(159, 3, 3'b011);
    plot_cycle(160, 1, 3'b111);
    plot_cycle(3, 120, 3'b111);
    plot_cycle(159, 119, 3'b011);
    if (CLEAR) begin
      repeat (60000) rand_cycle();
    end else begin
      repeat (2 * 2 * FRAME + 1000) rand_cycle();
    end
    idle_cycle();
    @(negedge clock);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_pixel_sink.md
Name: vga_pixel_sink

Overview:
- Receiving end of the pixel-plot interface that game logic drives with (x, y, colour, plot).
- Accepts plot writes into a 160x120, 3-bit-per-pixel framebuffer.
- Continuously scans the framebuffer out as 640x480 @ 60 Hz VGA, each logical pixel shown as a 4x4 block.
- Also gives game logic a one-clock frame_start strobe for frame pacing.

Parameters:
- H_VISIBLE, 640, visible pixel clocks per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch

Ports:
- clock  in  1  50 MHz system clock
- resetn  in  1  asynchronous active-low reset
- x  in  8  logical column, 0..159
- y  in  7  logical row, 0..119
- colour  in  3  {R,G,B} pixel value
- plot  in  1  write strobe, sampled every clock
- frame_start  out  1  one-clock pulse at the start of vertical blanking
- busy  out  1  high while the framebuffer is being cleared (optional feature only; otherwise tied 0)
- VGA_CLK  out  1  25 MHz pixel clock
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  low outside the visible region
- VGA_SYNC_N  out  1  constant 1
- VGA_R  out  10  red channel
- VGA_G  out  10  green channel
- VGA_B  out  10  blue channel

Behaviour:
- One clock domain (clock). resetn is asynchronous, active low; it clears all registers but not RAM contents.
- Reset values:
  - pix_en=0, h_cnt=0, v_cnt=0.
  - VGA_CLK=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - VGA_R/G/B=0, frame_start=0, busy=0.
- Pixel enable:
  - pix_en toggles every clock; VGA_CLK = pix_en register.
  - Counters and VGA outputs advance only on clocks where pix_en=1.
- Counters:
  - h_cnt runs 0..799 and wraps to 0; at that wrap v_cnt increments.
  - v_cnt runs 0..524 and wraps to 0.
- Raw timing, from counters:
  - hs_raw low for h_cnt in [656,751].
  - vs_raw low for v_cnt in [490,491].
  - vis = (h_cnt<640)&&(v_cnt<480).
- Read address:
  - rd_addr = (v_cnt>>2)*160 + (h_cnt>>2), 15 bits.
  - Multiply implemented as (row<<7)+(row<<5).
  - Only meaningful while vis=1.
- Read pipeline, fixed latency of 2 pixel ticks from counter value to pins:
  - Tick 1: rd_addr is registered into the synchronous RAM read.
  - Tick 2: VGA_R/G/B are registered.
  - hs_raw, vs_raw and vis go through a matching 2-stage delay so sync, blank and colour stay aligned.
- Colour expansion:
  - VGA_R = {10{colour_q[2]}}, VGA_G = {10{colour_q[1]}}, VGA_B = {10{colour_q[0]}}.
  - All three channels are forced to 0 when delayed vis=0.
- Write port:
  - When plot=1 and x<160 and y<120, mem[y*160+x] <= colour on that clock, at full 50 MHz rate, independent of pix_en.
  - Out-of-range coordinates are silently dropped.
- Read-during-write to the same address returns old data; the new value is visible from the next read.
- frame_start: asserted for exactly one clock, on the pix_en=1 clock where h_cnt=0 and v_cnt=480.
- Reset mid-frame: counters restart at 0,0. The first visible pixel reaches the pins 2 pixel ticks after reset release.

Optional Feature:
- Macro: VGA_PIXEL_SINK_CLEAR_EN.
- Defined:
  - After resetn deasserts, a clear sequencer writes 3'b000 to addresses 0..19199, one per clock.
  - busy=1 throughout the sweep; plot writes are ignored while busy=1.
  - busy falls on the clock after address 19199 is written.
  - Scan-out runs normally during the clear.
  - resetn asserted during the clear aborts it; it restarts from 0 after release.
- Not defined:
  - No sequencer; busy is constant 0.
  - RAM contents after reset are undefined or come from the init file; plot is accepted immediately.

Test Plan:
- Reset check: hold resetn=0 for 5 clocks -> VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, frame_start=0. After release, VGA_CLK toggles every clock.
- Line timing: measure VGA_HS -> period 1600 clocks, low 192 clocks. Falling edge occurs 656+2 pixel ticks after h_cnt=0. VGA_BLANK_N high 1280 clocks per visible line.
- Frame timing: frame_start period = 840000 clocks. VGA_VS low for 2 lines = 3200 clocks.
- Plot and display: plot x=0,y=0,colour=3'b100 and x=159,y=119,colour=3'b011 -> VGA_R=10'h3FF, G=B=0 on the first 4 pixels of lines 0..3. G=B=10'h3FF, R=0 on pixels 636..639 of lines 476..479.
- Range guard: plot x=160,y=5,colour=3'b111 and x=3,y=120,colour=3'b111 -> no RAM change; the pixel at (0,6) shows its prior value.
- With VGA_PIXEL_SINK_CLEAR_EN: busy=1 for exactly 19200 clocks after reset release. A plot at (10,10) issued during busy is ignored; after busy falls every pixel reads 0. Assert resetn at sweep address 5000 -> sweep restarts and busy lasts a full 19200 clocks.
